pulse_meter: RTL and testbench

PULSE_METER -- requirements
Module: pulse_meter

---
 rtl/pulse_meter_pkg.sv | 12 +
 rtl/edge_sync.sv | 33 +++
 rtl/pulse_meter.sv | 117 +++++++++++
 tb/tb_pulse_meter.sv | 316 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/pulse_meter_pkg.sv
// Shared types and defaults for the pulse meter.
package pulse_meter_pkg;

  localparam int unsigned DEFAULT_WIDTH = 8;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    HIGH = 2'd1,
    LOW  = 2'd2
  } state_e;

endpackage

// File: rtl/edge_sync.sv
// Two-flop synchronizer for the measured waveform plus rise/fall detect
// on the synchronized level.
module edge_sync (
  input  logic clock,
  input  logic reset_n,
  input  logic d,
  output logic q,
  output logic rise,
  output logic fall
);

  logic meta_q;
  logic sync_q;
  logic prev_q;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      meta_q <= 1'b0;
      sync_q <= 1'b0;
      prev_q <= 1'b0;
    end else begin
      meta_q <= d;
      sync_q <= meta_q;
      prev_q <= sync_q;
    end
  end

  // Edges are decoded from registered levels, so they are glitch-free.
  assign q    = sync_q;
  assign rise = sync_q & ~prev_q;
  assign fall = ~sync_q & prev_q;

endmodule

// File: rtl/pulse_meter.sv
// Measures high time, low time and period of an asynchronous pulse train,
// in clock cycles, with saturating counters and a sticky overflow flag.
module pulse_meter
  import pulse_meter_pkg::*;
#(
  parameter int unsigned WIDTH = DEFAULT_WIDTH
) (
  input  logic             clock,
  input  logic             reset_n,
  input  logic             signal,
  input  logic             clear,
  output logic [WIDTH-1:0] high_width,
  output logic [WIDTH-1:0] low_width,
  output logic [WIDTH:0]   period,
  output logic             valid,
  output logic             overflow
);

  localparam int unsigned PW = WIDTH + 1;
  localparam logic [WIDTH-1:0] CNT_MAX = '1;

  logic s;
  logic rise;
  logic fall;

  state_e           state_q;
  logic [WIDTH-1:0] hcnt_q;
  logic [WIDTH-1:0] lcnt_q;
  logic             ovf_q;
  logic [WIDTH-1:0] high_width_q;
  logic [WIDTH-1:0] low_width_q;
  logic [PW-1:0]    period_q;
  logic             valid_q;
  logic             overflow_q;

  edge_sync u_edge_sync (
    .clock  (clock),
    .reset_n(reset_n),
    .d      (signal),
    .q      (s),
    .rise   (rise),
    .fall   (fall)
  );

  // Measurement FSM; a period is rise -> fall -> rise, reported on the closing rise.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q      <= IDLE;
      hcnt_q       <= '0;
      lcnt_q       <= '0;
      ovf_q        <= 1'b0;
      high_width_q <= '0;
      low_width_q  <= '0;
      period_q     <= '0;
      valid_q      <= 1'b0;
      overflow_q   <= 1'b0;
    end else begin
      valid_q <= 1'b0;
      if (clear) begin
        state_q <= IDLE;
        hcnt_q  <= '0;
        lcnt_q  <= '0;
        ovf_q   <= 1'b0;
      end else begin
        case (state_q)
          IDLE: begin
            if (rise) begin
              state_q <= HIGH;
              hcnt_q  <= WIDTH'(1);
              lcnt_q  <= '0;
              ovf_q   <= 1'b0;
            end
          end
          HIGH: begin
            if (fall) begin
              state_q <= LOW;
              lcnt_q  <= WIDTH'(1);
            end else if (s) begin
              if (hcnt_q == CNT_MAX) begin
                ovf_q <= 1'b1;
              end else begin
                hcnt_q <= hcnt_q + WIDTH'(1);
              end
            end
          end
          LOW: begin
            if (rise) begin
              high_width_q <= hcnt_q;
              low_width_q  <= lcnt_q;
              period_q     <= PW'(hcnt_q) + PW'(lcnt_q);
              overflow_q   <= ovf_q;
              valid_q      <= 1'b1;
              state_q      <= HIGH;
              hcnt_q       <= WIDTH'(1);
              lcnt_q       <= '0;
              ovf_q        <= 1'b0;
            end else if (!s) begin
              if (lcnt_q == CNT_MAX) begin
                ovf_q <= 1'b1;
              end else begin
                lcnt_q <= lcnt_q + WIDTH'(1);
              end
            end
          end
          default: state_q <= IDLE;
        endcase
      end
    end
  end

  assign high_width = high_width_q;
  assign low_width  = low_width_q;
  assign period     = period_q;
  assign valid      = valid_q;
  assign overflow   = overflow_q;

endmodule

// File: tb/tb_pulse_meter.sv
// Self-checking bench for pulse_meter: directed and randomized pulse trains
// compared against a period-level reference model.
module tb_pulse_meter;

  localparam int unsigned W = 8;
  localparam int MAXC = (1 << W) - 1;

  typedef struct packed {
    logic [W-1:0] h;
    logic [W-1:0] l;
    logic [W:0]   p;
    logic         o;
  } res_t;

  logic         clock   = 1'b0;
  logic         reset_n = 1'b0;
  logic         signal  = 1'b0;
  logic         clear   = 1'b0;
  logic [W-1:0] high_width;
  logic [W-1:0] low_width;
  logic [W:0]   period;
  logic         valid;
  logic         overflow;

  int n_cmp  = 0;
  int n_fail = 0;
  int unsigned cyc = 0;

  res_t        obs_q[$];
  int unsigned obs_cyc[$];
  int          seg_h[$];
  int          seg_l[$];

  pulse_meter #(.WIDTH(W)) dut (
    .clock     (clock),
    .reset_n   (reset_n),
    .signal    (signal),
    .clear     (clear),
    .high_width(high_width),
    .low_width (low_width),
    .period    (period),
    .valid     (valid),
    .overflow  (overflow)
  );

  always #5 clock = ~clock;

  always @(posedge clock) cyc <= cyc + 1;

  always @(posedge clock) begin
    #1;
    if (valid === 1'b1) begin
      obs_q.push_back({high_width, low_width, period, overflow});
      obs_cyc.push_back(cyc);
    end
  end

  // A period of h high cycles and l low cycles, reported with saturation.
  function automatic res_t model(input int h, input int l);
    res_t r;
    int hs;
    int ls;
    hs = (h > MAXC) ? MAXC : h;
    ls = (l > MAXC) ? MAXC : l;
    r.h = W'(hs);
    r.l = W'(ls);
    r.p = (W + 1)'(hs + ls);
    r.o = (h > MAXC) || (l > MAXC);
    return r;
  endfunction

  task automatic drive(input bit v, input int n);
    signal = v;
    repeat (n) @(negedge clock);
  endtask

  task automatic restart();
    signal = 1'b0;
    repeat (5) @(negedge clock);
    clear = 1'b1;
    @(negedge clock);
    clear = 1'b0;
    @(negedge clock);
    obs_q.delete();
    obs_cyc.delete();
  endtask

  // Plays seg_h/seg_l as consecutive periods, then a closing rise.
  task automatic play();
    for (int i = 0; i < seg_h.size(); i++) begin
      drive(1'b1, seg_h[i]);
      drive(1'b0, seg_l[i]);
    end
    drive(1'b1, 6);
    drive(1'b0, 4);
  endtask

  task automatic test_reset();
    repeat (3) begin
      signal = ~signal;
      @(negedge clock);
    end
    n_cmp++;
    if ({high_width, low_width, period, valid, overflow} !== '0) begin
      n_fail++;
      $display("FAIL reset_hold: outputs=%h required 0", {high_width, low_width, period, valid, overflow});
    end
    signal  = 1'b0;
    reset_n = 1'b1;
    drive(1'b0, 5);
    n_cmp++;
    if (high_width !== '0 || low_width !== '0 || period !== '0) begin
      n_fail++;
      $display("FAIL reset_results: h=%0d l=%0d p=%0d required 0", high_width, low_width, period);
    end
    n_cmp++;
    if (valid !== 1'b0 || overflow !== 1'b0 || obs_q.size() != 0) begin
      n_fail++;
      $display("FAIL reset_flags: valid=%b overflow=%b strobes=%0d required 0", valid, overflow, obs_q.size());
    end
  endtask

  task automatic test_directed_periods();
    int tab_h[3] = '{4, 5, 1};
    int tab_l[3] = '{4, 15, 7};
    res_t e;
    for (int t = 0; t < 3; t++) begin
      restart();
      seg_h.delete();
      seg_l.delete();
      for (int k = 0; k < 3; k++) begin
        seg_h.push_back(tab_h[t]);
        seg_l.push_back(tab_l[t]);
      end
      play();
      e = model(tab_h[t], tab_l[t]);
      n_cmp++;
      if (obs_q.size() != 3) begin
        n_fail++;
        $display("FAIL periods_%0d_%0d count: got %0d strobes, required 3", tab_h[t], tab_l[t], obs_q.size());
      end
      for (int i = 0; i < obs_q.size() && i < 3; i++) begin
        n_cmp++;
        if (obs_q[i] !== e) begin
          n_fail++;
          $display("FAIL periods_%0d_%0d[%0d]: got h=%0d l=%0d p=%0d o=%0d, required h=%0d l=%0d p=%0d o=%0d",
                   tab_h[t], tab_l[t], i, obs_q[i].h, obs_q[i].l, obs_q[i].p, obs_q[i].o, e.h, e.l, e.p, e.o);
        end
      end
      n_cmp++;
      if ({high_width, low_width, period, overflow} !== e || valid !== 1'b0) begin
        n_fail++;
        $display("FAIL hold_%0d_%0d: got h=%0d l=%0d p=%0d o=%0d v=%b, required h=%0d l=%0d p=%0d o=%0d v=0",
                 tab_h[t], tab_l[t], high_width, low_width, period, overflow, valid, e.h, e.l, e.p, e.o);
      end
    end
  endtask

  task automatic test_overflow();
    res_t e0;
    res_t e1;
    restart();
    seg_h = '{300, 4};
    seg_l = '{10, 4};
    play();
    e0 = model(300, 10);
    e1 = model(4, 4);
    n_cmp++;
    if (obs_q.size() != 2) begin
      n_fail++;
      $display("FAIL overflow count: got %0d strobes, required 2", obs_q.size());
    end else begin
      n_cmp++;
      if (obs_q[0] !== e0) begin
        n_fail++;
        $display("FAIL overflow_sat: got h=%0d l=%0d p=%0d o=%0d, required h=%0d l=%0d p=%0d o=%0d",
                 obs_q[0].h, obs_q[0].l, obs_q[0].p, obs_q[0].o, e0.h, e0.l, e0.p, e0.o);
      end
      n_cmp++;
      if (obs_q[1] !== e1) begin
        n_fail++;
        $display("FAIL overflow_next: got h=%0d l=%0d p=%0d o=%0d, required h=%0d l=%0d p=%0d o=%0d",
                 obs_q[1].h, obs_q[1].l, obs_q[1].p, obs_q[1].o, e1.h, e1.l, e1.p, e1.o);
      end
    end
  endtask

  task automatic test_latency();
    int unsigned c_rise;
    restart();
    drive(1'b1, 3);
    drive(1'b0, 3);
    c_rise = cyc;
    drive(1'b1, 6);
    drive(1'b0, 4);
    n_cmp++;
    if (obs_cyc.size() != 1 || obs_cyc[0] != c_rise + 3) begin
      n_fail++;
      $display("FAIL valid_latency: got %0d strobes, first at cycle %0d, required 1 at cycle %0d",
               obs_cyc.size(), (obs_cyc.size() > 0) ? obs_cyc[0] : 0, c_rise + 3);
    end
  endtask

  task automatic test_reset_mid();
    res_t e;
    restart();
    seg_h = '{4};
    seg_l = '{4};
    play();
    drive(1'b0, 3);
    reset_n = 1'b0;
    #1;
    n_cmp++;
    if ({high_width, low_width, period, valid, overflow} !== '0) begin
      n_fail++;
      $display("FAIL reset_mid_async: got h=%0d l=%0d p=%0d v=%b o=%b, required all 0",
               high_width, low_width, period, valid, overflow);
    end
    @(negedge clock);
    drive(1'b1, 2);
    signal = 1'b0;
    @(negedge clock);
    reset_n = 1'b1;
    obs_q.delete();
    drive(1'b0, 3);
    seg_h = '{3};
    seg_l = '{5};
    play();
    e = model(3, 5);
    n_cmp++;
    if (obs_q.size() != 1 || obs_q[0] !== e) begin
      n_fail++;
      $display("FAIL reset_mid_first: got %0d strobes, first=%h, required 1 strobe %h",
               obs_q.size(), (obs_q.size() > 0) ? obs_q[0] : res_t'(0), e);
    end
  endtask

  task automatic test_clear_rise();
    res_t e0;
    res_t e1;
    restart();
    drive(1'b1, 4);
    drive(1'b0, 4);
    drive(1'b1, 6);
    drive(1'b0, 2);
    e0 = model(4, 4);
    signal = 1'b1;
    repeat (2) @(negedge clock);
    clear = 1'b1;
    @(negedge clock);
    clear = 1'b0;
    repeat (4) @(negedge clock);
    n_cmp++;
    if (obs_q.size() != 1) begin
      n_fail++;
      $display("FAIL clear_suppress: got %0d strobes, required 1", obs_q.size());
    end
    n_cmp++;
    if ({high_width, low_width, period, overflow} !== e0) begin
      n_fail++;
      $display("FAIL clear_keep: got h=%0d l=%0d p=%0d o=%0d, required h=%0d l=%0d p=%0d o=%0d",
               high_width, low_width, period, overflow, e0.h, e0.l, e0.p, e0.o);
    end
    drive(1'b0, 3);
    drive(1'b1, 2);
    drive(1'b0, 3);
    drive(1'b1, 6);
    drive(1'b0, 4);
    e1 = model(2, 3);
    n_cmp++;
    if (obs_q.size() != 2 || obs_q[obs_q.size()-1] !== e1) begin
      n_fail++;
      $display("FAIL clear_idle: got %0d strobes, last=%h, required 2 with last %h",
               obs_q.size(), (obs_q.size() > 0) ? obs_q[obs_q.size()-1] : res_t'(0), e1);
    end
  endtask

  task automatic test_random();
    res_t e;
    restart();
    seg_h.delete();
    seg_l.delete();
    for (int k = 0; k < 12; k++) begin
      seg_h.push_back(($urandom_range(0, 9) == 0) ? int'($urandom_range(250, 280)) : int'($urandom_range(1, 40)));
      seg_l.push_back(($urandom_range(0, 9) == 0) ? int'($urandom_range(250, 280)) : int'($urandom_range(1, 40)));
    end
    play();
    n_cmp++;
    if (obs_q.size() != seg_h.size()) begin
      n_fail++;
      $display("FAIL random count: got %0d strobes, required %0d", obs_q.size(), seg_h.size());
    end
    for (int i = 0; i < obs_q.size() && i < seg_h.size(); i++) begin
      e = model(seg_h[i], seg_l[i]);
      n_cmp++;
      if (obs_q[i] !== e) begin
        n_fail++;
        $display("FAIL random[%0d] (%0d/%0d): got h=%0d l=%0d p=%0d o=%0d, required h=%0d l=%0d p=%0d o=%0d",
                 i, seg_h[i], seg_l[i], obs_q[i].h, obs_q[i].l, obs_q[i].p, obs_q[i].o, e.h, e.l, e.p, e.o);
      end
    end
  endtask

  initial begin
    test_reset();
    test_directed_periods();
    test_overflow();
    test_latency();
    test_reset_mid();
    test_clear_rise();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
